// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Size codes match the controller's mem_u_b_h_w field: bit2 unsigned, bit1 word, bit0 half.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int MID_W = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the master that wins a tie
// and moves to the other master on every accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After M0 wins the pointer favours M1, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         ptr <= 1'b0;
    else if (advance && (|gnt))      ptr <= gnt[0];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory controller's CPU-side port between the CPU (M0) and the DMA engine (M1).
// Each access is latched at grant, strobed for its full duration, then completed with a done pulse.
//
// state  | meaning
// IDLE   | no access in progress, may grant
// ACCESS | strobe driven, cnt counting down to the rdata sample
// RESP   | done pulse to the owner
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [2:0]  m0_size,
  input  logic [2:0]  m1_size,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_u_b_h_w,
  input  logic [31:0] mem_rdata
);

  arb_state_t        state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [31:0]       addr_l, addr_nxt;
  logic [31:0]       wdata_l, wdata_nxt;
  logic              we_l, we_nxt;
  logic [2:0]        size_l, size_nxt;
  logic [MID_W-1:0]  owner_l, owner_nxt;
  logic              m0_gnt_nxt, m1_gnt_nxt;
  logic [31:0]       m0_rdata_nxt, m1_rdata_nxt;
  logic [1:0]        arb_pick;
  logic              arb_adv;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_req, m0_req}),
    .advance (arb_adv),
    .gnt     (arb_pick)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_l;
    wdata_nxt    = wdata_l;
    we_nxt       = we_l;
    size_nxt     = size_l;
    owner_nxt    = owner_l;
    m0_gnt_nxt   = 1'b0;
    m1_gnt_nxt   = 1'b0;
    m0_rdata_nxt = m0_rdata;
    m1_rdata_nxt = m1_rdata;
    arb_adv      = 1'b0;
    case (state)
      IDLE: begin
        if (|arb_pick) begin
          arb_adv    = 1'b1;
          state_nxt  = ACCESS;
          m0_gnt_nxt = arb_pick[0];
          m1_gnt_nxt = arb_pick[1];
          owner_nxt  = arb_pick[1];
          addr_nxt   = arb_pick[1] ? m1_addr  : m0_addr;
          wdata_nxt  = arb_pick[1] ? m1_wdata : m0_wdata;
          we_nxt     = arb_pick[1] ? m1_we    : m0_we;
          size_nxt   = arb_pick[1] ? m1_size  : m0_size;
          cnt_nxt    = we_nxt ? 3'd0 : 3'(RD_LATENCY);
        end
      end
      ACCESS: begin
        if (cnt == 3'd0) begin
          state_nxt = RESP;
          if (!we_l) begin
            if (owner_l[0]) m1_rdata_nxt = mem_rdata;
            else            m0_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      addr_l   <= 32'd0;
      wdata_l  <= 32'd0;
      we_l     <= 1'b0;
      size_l   <= 3'd0;
      owner_l  <= '0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_rdata <= 32'd0;
      m1_rdata <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr_l   <= addr_nxt;
      wdata_l  <= wdata_nxt;
      we_l     <= we_nxt;
      size_l   <= size_nxt;
      owner_l  <= owner_nxt;
      m0_gnt   <= m0_gnt_nxt;
      m1_gnt   <= m1_gnt_nxt;
      m0_rdata <= m0_rdata_nxt;
      m1_rdata <= m1_rdata_nxt;
    end
  end

  // Strobes decode straight from registers so an async reset drops them at once.
  assign mem_read    = (state == ACCESS) && !we_l;
  assign mem_write   = (state == ACCESS) &&  we_l;
  assign mem_addr    = addr_l;
  assign mem_wdata   = wdata_l;
  assign mem_u_b_h_w = size_l;
  assign m0_done     = (state == RESP) && !owner_l[0];
  assign m1_done     = (state == RESP) &&  owner_l[0];

endmodule
